// File: rtl/elevator_scan_scheduler_pkg.sv
// Shared types and defaults for the elevator SCAN scheduler.
package elevator_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_WAIT_ARR,
    ST_DOOR
  } state_t;

  // Scan direction encoding as seen on dir_up
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Default building geometry and door dwell
  localparam int DEF_N_FLOORS    = 5;
  localparam int DEF_DOOR_CYCLES = 4;

endpackage

// File: rtl/elevator_scan_scheduler_if.sv
// Bundle of call, target handshake, arrival and status signals between the
// scheduler (master) and the surrounding front end / car controller (slave).
interface elevator_scan_scheduler_if
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = DEF_N_FLOORS
);
  localparam int FW = $clog2(N_FLOORS);

  logic [N_FLOORS-1:0] call_req;
  logic [FW-1:0]       cur_floor;
  logic [FW-1:0]       tgt_floor;
  logic                tgt_valid;
  logic                tgt_ready;
  logic                arrived;
  logic [FW-1:0]       arr_floor;
  logic [N_FLOORS-1:0] pending;
  logic                dir_up;
  logic                door_open;
  logic                busy;

  modport master (
    input  call_req, cur_floor, tgt_ready, arrived, arr_floor,
    output tgt_floor, tgt_valid, pending, dir_up, door_open, busy
  );

  modport slave (
    output call_req, cur_floor, tgt_ready, arrived, arr_floor,
    input  tgt_floor, tgt_valid, pending, dir_up, door_open, busy
  );

endinterface

// File: rtl/elevator_scan_scheduler_scan_pick.sv
// Combinational SCAN target search: prefer the nearest pending floor in the
// current direction (including the car's own floor), otherwise reverse and
// take the nearest pending floor behind the car.
module scan_pick
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = DEF_N_FLOORS,
  parameter int FW       = $clog2(N_FLOORS)
) (
  input  logic [N_FLOORS-1:0] pending,
  input  logic [FW-1:0]       cur_floor,
  input  logic                dir_up,
  output logic                found,
  output logic [FW-1:0]       pick_floor,
  output logic                new_dir
);

  int   cur;
  int   lo_ge, lo_gt, hi_le, hi_lt;
  logic has_lo_ge, has_lo_gt, has_hi_le, has_hi_lt;

  // Locate nearest pending floors on each side of the (saturated) car floor
  always_comb begin
    cur = int'(cur_floor);
    if (cur > N_FLOORS - 1) cur = N_FLOORS - 1;
    lo_ge = 0; lo_gt = 0; hi_le = 0; hi_lt = 0;
    has_lo_ge = 1'b0; has_lo_gt = 1'b0; has_hi_le = 1'b0; has_hi_lt = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending[i]) begin
        if (i >= cur && !has_lo_ge) begin has_lo_ge = 1'b1; lo_ge = i; end
        if (i >  cur && !has_lo_gt) begin has_lo_gt = 1'b1; lo_gt = i; end
        if (i <= cur) begin has_hi_le = 1'b1; hi_le = i; end
        if (i <  cur) begin has_hi_lt = 1'b1; hi_lt = i; end
      end
    end

    found      = |pending;
    pick_floor = '0;
    new_dir    = dir_up;
    if (dir_up == DIR_UP) begin
      if (has_lo_ge) begin
        pick_floor = FW'(lo_ge);
      end else if (has_hi_lt) begin
        pick_floor = FW'(hi_lt);
        new_dir    = DIR_DOWN;
      end
    end else begin
      if (has_hi_le) begin
        pick_floor = FW'(hi_le);
      end else if (has_lo_gt) begin
        pick_floor = FW'(lo_gt);
        new_dir    = DIR_UP;
      end
    end
  end

endmodule

// File: rtl/elevator_scan_scheduler.sv
// Elevator SCAN scheduler: latches floor calls, issues one target at a time
// over a valid/ready handshake, and times the door at each served floor.
module elevator_scan_scheduler
  import elevator_pkg::*;
#(
  parameter int N_FLOORS    = DEF_N_FLOORS,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  elevator_scan_scheduler_if.master  bus
);

  localparam int FW = $clog2(N_FLOORS);
  localparam int CW = $clog2(DOOR_CYCLES + 1);

  state_t              state_q, state_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [FW-1:0]       tgt_floor_q, tgt_floor_d;
  logic                tgt_valid_q, tgt_valid_d;
  logic                dir_up_q, dir_up_d;
  logic                door_open_q, door_open_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                found;
  logic [FW-1:0]       pick_floor;
  logic                new_dir;

  scan_pick #(
    .N_FLOORS (N_FLOORS),
    .FW       (FW)
  ) u_scan_pick (
    .pending    (pending_q),
    .cur_floor  (bus.cur_floor),
    .dir_up     (dir_up_q),
    .found      (found),
    .pick_floor (pick_floor),
    .new_dir    (new_dir)
  );

  // State and datapath registers; reset discards every outstanding call
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      tgt_floor_q <= '0;
      tgt_valid_q <= 1'b0;
      dir_up_q    <= DIR_UP;
      door_open_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      tgt_floor_q <= tgt_floor_d;
      tgt_valid_q <= tgt_valid_d;
      dir_up_q    <= dir_up_d;
      door_open_q <= door_open_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic; a served arrival clears its floor after new calls are
  // merged so a same-cycle call at that floor is absorbed by the door opening
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | bus.call_req;
    tgt_floor_d = tgt_floor_q;
    tgt_valid_d = tgt_valid_q;
    dir_up_d    = dir_up_q;
    door_open_d = door_open_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (found) begin
          tgt_floor_d = pick_floor;
          dir_up_d    = new_dir;
          tgt_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.tgt_ready) begin
          tgt_valid_d = 1'b0;
          state_d     = ST_WAIT_ARR;
        end
      end
      ST_WAIT_ARR: begin
        if (bus.arrived && (bus.arr_floor == tgt_floor_q)) begin
          pending_d   = pending_d & ~(N_FLOORS'(1) << tgt_floor_q);
          door_open_d = 1'b1;
          cnt_d       = CW'(DOOR_CYCLES);
          state_d     = ST_DOOR;
        end
      end
      ST_DOOR: begin
        if (cnt_q <= CW'(1)) begin
          door_open_d = 1'b0;
          cnt_d       = '0;
          state_d     = (pending_q != '0) ? ST_SELECT : ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs straight from registers
  assign bus.tgt_floor = tgt_floor_q;
  assign bus.tgt_valid = tgt_valid_q;
  assign bus.pending   = pending_q;
  assign bus.dir_up    = dir_up_q;
  assign bus.door_open = door_open_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_elevator_scan_scheduler.sv
// Self-checking bench: the bench plays the car controller and compares the
// scheduler against a call-list model that picks SCAN targets directly from
// the set of outstanding floors.
module tb_elevator_scan_scheduler;
  import elevator_pkg::*;

  localparam int N  = 5;
  localparam int D  = 4;
  localparam int FW = $clog2(N);

  logic clk = 1'b0;
  logic reset;

  elevator_scan_scheduler_if #(.N_FLOORS(N)) bus ();

  elevator_scan_scheduler #(
    .N_FLOORS    (N),
    .DOOR_CYCLES (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [N-1:0]  m_pend;
  logic          m_dir;
  bit            awaiting;
  int            tgt_acc;
  int            delay;
  int            door_cnt;
  logic          prev_valid;
  logic [FW-1:0] held_tgt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // SCAN choice from the call set: nearest call ahead, else nearest behind
  function automatic int ref_pick(input logic [N-1:0] p, input int cur_in,
                                  input logic dir, output logic nd);
    int c, best;
    c    = (cur_in > N - 1) ? N - 1 : cur_in;
    best = -1;
    nd   = dir;
    if (dir) begin
      for (int f = 0; f < N; f++)
        if (p[f] && f >= c && (best < 0 || f < best)) best = f;
      if (best < 0) begin
        for (int f = 0; f < N; f++)
          if (p[f] && f < c && f > best) best = f;
        if (best >= 0) nd = 1'b0;
      end
    end else begin
      for (int f = 0; f < N; f++)
        if (p[f] && f <= c && f > best) best = f;
      if (best < 0) begin
        for (int f = 0; f < N; f++)
          if (p[f] && f > c && (best < 0 || f < best)) best = f;
        if (best >= 0) nd = 1'b1;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_pend     = '0;
    m_dir      = 1'b1;
    awaiting   = 0;
    tgt_acc    = 0;
    delay      = 0;
    door_cnt   = 0;
    prev_valid = 1'b0;
    held_tgt   = '0;
  endtask

  // One clock: note what the edge should do, advance, then compare
  task automatic step();
    logic [N-1:0] pend_before;
    logic         acc, srv, nd;
    logic [FW-1:0] tgt_at_edge;
    int           cur_before, exp_tgt;
    acc         = bus.tgt_valid && bus.tgt_ready;
    srv         = awaiting && bus.arrived && (int'(bus.arr_floor) == tgt_acc);
    tgt_at_edge = bus.tgt_floor;
    pend_before = m_pend;
    cur_before  = int'(bus.cur_floor);
    @(posedge clk);
    #1;
    m_pend = m_pend | bus.call_req;
    if (srv) m_pend[tgt_acc] = 1'b0;
    check_val("pending", 32'(bus.pending), 32'(m_pend));

    if (srv) begin
      awaiting      = 0;
      bus.cur_floor = FW'(tgt_acc);
      door_cnt      = 1;
      check_val("door_on", 32'(bus.door_open), 32'd1);
      $display("TXN arrive floor=%0d pending=%b", tgt_acc, bus.pending);
    end else if (door_cnt > 0) begin
      if (bus.door_open) begin
        door_cnt++;
        if (door_cnt > D) begin
          check_val("door_len", 32'(door_cnt), 32'(D));
          door_cnt = 0;
        end
      end else begin
        check_val("door_len", 32'(door_cnt), 32'(D));
        door_cnt = 0;
      end
    end else begin
      check_val("door_off", 32'(bus.door_open), 32'd0);
    end

    if (acc) begin
      awaiting = 1;
      tgt_acc  = int'(tgt_at_edge);
      delay    = $urandom_range(0, 4);
      check_val("valid_drop", 32'(bus.tgt_valid), 32'd0);
      $display("TXN accept tgt=%0d dir_up=%0d", tgt_acc, bus.dir_up);
    end else if (prev_valid) begin
      check_val("valid_hold", 32'(bus.tgt_valid), 32'd1);
      check_val("tgt_hold", 32'(bus.tgt_floor), 32'(held_tgt));
    end

    if (bus.tgt_valid && !prev_valid) begin
      exp_tgt = ref_pick(pend_before, cur_before, m_dir, nd);
      check_val("tgt", 32'(bus.tgt_floor), 32'(exp_tgt));
      m_dir = nd;
    end
    check_val("dir", 32'(bus.dir_up), 32'(m_dir));
    if (bus.tgt_valid || awaiting || bus.door_open)
      check_val("busy", 32'(bus.busy), 32'd1);

    prev_valid = bus.tgt_valid;
    held_tgt   = bus.tgt_floor;
  endtask

  // Car-controller behaviour plus random calls for the next cycle
  task automatic drive_car(input bit calls_on);
    bus.call_req  = (calls_on && $urandom_range(0, 5) == 0) ? N'($urandom) : '0;
    bus.tgt_ready = ($urandom_range(0, 2) == 0);
    bus.arrived   = 1'b0;
    bus.arr_floor = FW'($urandom_range(0, N - 1));
    if (awaiting) begin
      if (delay == 0) begin
        bus.arrived   = 1'b1;
        bus.arr_floor = FW'(tgt_acc);
      end else begin
        delay--;
        if ($urandom_range(0, 3) == 0) begin
          bus.arrived   = 1'b1;
          bus.arr_floor = FW'((tgt_acc + 1 + int'($urandom_range(0, N - 2))) % N);
        end
      end
    end
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      drive_car(1'b0);
      step();
      if (!bus.busy && m_pend == '0 && !bus.tgt_valid && !awaiting) done = 1;
    end
    check_val(tag, 32'(done), 32'd1);
    check_val("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit got_door;
    reset         = 1'b1;
    bus.call_req  = '0;
    bus.cur_floor = '0;
    bus.tgt_ready = 1'b0;
    bus.arrived   = 1'b0;
    bus.arr_floor = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_pending", 32'(bus.pending), 32'd0);
    check_val("rst_valid", 32'(bus.tgt_valid), 32'd0);
    check_val("rst_tgt", 32'(bus.tgt_floor), 32'd0);
    check_val("rst_dir", 32'(bus.dir_up), 32'd1);
    check_val("rst_door", 32'(bus.door_open), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;

    // Single call from idle at floor 0, then a 10-cycle handshake stall
    bus.call_req = 5'b01000;
    step();
    bus.call_req = '0;
    step();
    step();
    check_val("valid_c3", 32'(bus.tgt_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      bus.call_req = (k == 4) ? 5'b00010 : 5'b00000;
      step();
    end
    bus.call_req  = '0;
    bus.tgt_ready = 1'b1;
    step();
    bus.tgt_ready = 1'b0;

    // Arrival at a passed floor that is pending must be ignored
    bus.arrived   = 1'b1;
    bus.arr_floor = 3'd1;
    step();
    check_val("wrong_pend1", 32'(bus.pending[1]), 32'd1);
    check_val("wrong_busy", 32'(bus.busy), 32'd1);

    // Served arrival with simultaneous calls at the served floor and floor 0
    bus.arr_floor = 3'd3;
    bus.call_req  = 5'b01001;
    step();
    bus.arrived  = 1'b0;
    bus.call_req = '0;
    check_val("clr_wins", 32'(bus.pending[3]), 32'd0);
    check_val("set_other", 32'(bus.pending[0]), 32'd1);
    drain("drain1");

    // Out-of-range car floor saturates to the top floor
    bus.cur_floor = 3'd7;
    bus.call_req  = 5'b01010;
    step();
    drain("drain_sat");

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      drive_car(1'b1);
      step();
    end
    drain("drain_rand");

    // Reset in the middle of a door sequence with calls outstanding
    got_door = 0;
    bus.call_req = 5'b00100;
    step();
    for (int k = 0; k < 400 && !got_door; k++) begin
      drive_car(1'b0);
      step();
      if (bus.door_open) got_door = 1;
    end
    check_val("door_wait", 32'(got_door), 32'd1);
    bus.call_req = 5'b10010;
    bus.arrived  = 1'b0;
    step();
    bus.call_req = '0;
    #2 reset = 1'b1;
    #1;
    check_val("arst_pending", 32'(bus.pending), 32'd0);
    check_val("arst_valid", 32'(bus.tgt_valid), 32'd0);
    check_val("arst_door", 32'(bus.door_open), 32'd0);
    check_val("arst_busy", 32'(bus.busy), 32'd0);
    check_val("arst_dir", 32'(bus.dir_up), 32'd1);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    bus.tgt_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check_val("post_rst_valid", 32'(bus.tgt_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/elevator_scan_scheduler.md
Name: elevator_scan_scheduler

Overview:
- Sequences the elevator car: collects floor call buttons into a pending bitmap and issues one target floor at a time to the car controller over a valid/ready handshake.
- Uses SCAN ordering: keep serving in the current direction, reverse only when nothing remains ahead.
- Owns door timing at each served floor.
- Sits between the button/keypad front end and the car motion controller.

Parameters:
- N_FLOORS, 5, number of floors, indexed 0..N_FLOORS-1 (2..16 legal).
- DOOR_CYCLES, 4, clock cycles door_open is held at a served floor (>=1).
- FW, $clog2(N_FLOORS), floor index width (derived, not overridable).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- call_req  in  N_FLOORS  call pulses, bit i = floor i pressed; multiple bits may be set.
- cur_floor  in  FW  car's current floor, binary.
- tgt_floor  out  FW  target floor offered to car.
- tgt_valid  out  1  tgt_floor valid; held until accepted.
- tgt_ready  in  1  car accepts target when tgt_valid & tgt_ready.
- arrived  in  1  one-cycle pulse: car stopped at arr_floor.
- arr_floor  in  FW  floor reported with arrived.
- pending  out  N_FLOORS  registered outstanding-call bitmap.
- dir_up  out  1  scan direction, 1 = up, 0 = down.
- door_open  out  1  door command, 1 = open.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async): state=IDLE; pending=0, tgt_floor=0, tgt_valid=0, dir_up=1, door_open=0, busy=0, door counter=0.
- Pending register:
  - pending[i] set on the cycle after call_req[i]=1.
  - Cleared only on a served arrival.
  - A call at a floor already pending is absorbed with no effect.
- States: IDLE, SELECT, ISSUE, WAIT_ARR, DOOR.
- IDLE:
  - pending!=0 -> SELECT at the next edge.
  - A call arriving in IDLE therefore reaches SELECT 2 cycles after the call_req edge.
- SELECT (exactly 1 cycle): choose the target from pending and cur_floor (saturated to N_FLOORS-1 if out of range).
  - dir_up=1: lowest pending floor >= cur_floor. If none, highest pending floor < cur_floor, and dir_up<=0.
  - dir_up=0: highest pending floor <= cur_floor. If none, lowest pending floor > cur_floor, and dir_up<=1.
  - Register tgt_floor, go to ISSUE.
  - If pending became 0 this cycle, go to IDLE instead.
- ISSUE:
  - tgt_valid=1 and tgt_floor stable until tgt_ready=1.
  - On the accept edge: tgt_valid<=0, go to WAIT_ARR.
  - tgt_ready outside ISSUE is ignored.
- WAIT_ARR:
  - Wait for arrived=1 with arr_floor==tgt_floor.
  - Then clear pending[tgt_floor], door_open<=1, load counter=DOOR_CYCLES, go to DOOR.
  - arrived with any other arr_floor is ignored; the bit for a passed floor stays pending.
  - New calls are accepted but never retarget an issued floor.
- DOOR:
  - door_open=1 for exactly DOOR_CYCLES cycles, counter decrements each cycle.
  - At counter==1: door_open<=0, then SELECT if pending!=0, else IDLE.
- Simultaneous events:
  - call_req[i] in the same cycle as a served arrival at floor i: the clear wins, and the call is treated as served by that door opening.
  - Calls for other floors in that cycle are set normally.
- Call at the floor the car is parked on, from IDLE: issued like any target (target==cur_floor); the car responds with an immediate arrived, and the door sequence runs.
- Reset asserted mid-operation: returns to reset values immediately, all pending calls discarded. The car controller is expected to be reset together with this block.
- No wrap-around on floors. Direction reversal happens only via the SELECT rules above.

Decomposition:
- Shared package elevator_pkg:
  - state enum (IDLE/SELECT/ISSUE/WAIT_ARR/DOOR).
  - DIR_UP/DIR_DOWN constants.
  - default N_FLOORS and DOOR_CYCLES.
- One sub-module, scan_pick (combinational). Inputs: pending, cur_floor, dir_up. Outputs: found, pick_floor, new_dir. Implements the SELECT priority search; unit-testable alone.
- The top module holds the pending register, FSM, handshake and door counter.

Test Plan:
- Single call from idle, N=5: cur_floor=0, call_req=5'b01000 -> pending[3]=1 next cycle; tgt_valid=1 with tgt_floor=3 by cycle 3; after tgt_ready and arrived(arr_floor=3), door_open=1 for exactly 4 cycles, pending=0, FSM back in IDLE.
- SCAN order: cur_floor=2, dir_up=1, pending={0,4,3} -> targets issued 3, 4, 0 in that order; dir_up goes 0 only when 0 is selected.
- Handshake stall: hold tgt_ready=0 for 10 cycles -> tgt_valid stays 1, tgt_floor constant; a new call_req[1] during the stall sets pending[1] without changing tgt_floor.
- Same-cycle clear vs set: call_req[3]=1 in the arrived(arr_floor=3) cycle -> pending[3]=0 afterward; a simultaneous call_req[1] -> pending[1]=1.
- Wrong-floor arrival: tgt=4, arrived with arr_floor=2 while pending[2]=1 -> state stays WAIT_ARR, pending[2] remains set, door_open=0.
- Reset mid-DOOR with pending=5'b10010 -> outputs return to reset values asynchronously; no tgt_valid after reset deasserts until a new call arrives.
